sram_tiled_wrapper: RTL and testbench

Parametrised successor to the fixed 128b x 2048 IHP-SG13G2 SRAM wrapper. It tiles RM_IHPSG13_1P_2048x64_c2_bm_bist macros in width (columns) and depth (banks). It adds per-bit write masking, a registered read bank select with a read-valid strobe, and a post-reset zero-initialisation sweep FSM. It is a drop-in replacement for activation, weight and psum buffers in the accelerator core.

---
 rtl/sram_tiled_wrapper.sv | 170 +++++++++++++++++
 tb/tb_sram_tiled_wrapper.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_tiled_wrapper.sv
// Tiled SRAM built from 2048x64 single-port macros. Provides per-bit write masking,
// a registered read bank select with a Q_VALID strobe, and an optional zero-fill sweep after reset.

// Behavioural stand-in for the hard macro. The technology library cell of the same name
// replaces it in implementation.
module RM_IHPSG13_1P_2048x64_c2_bm_bist (
    input  logic        A_CLK,
    input  logic        A_MEN,
    input  logic        A_WEN,
    input  logic        A_REN,
    input  logic [10:0] A_ADDR,
    input  logic [63:0] A_DIN,
    input  logic        A_DLY,
    output logic [63:0] A_DOUT,
    input  logic [63:0] A_BM,
    input  logic        A_BIST_CLK,
    input  logic        A_BIST_EN,
    input  logic        A_BIST_MEN,
    input  logic        A_BIST_WEN,
    input  logic        A_BIST_REN,
    input  logic [10:0] A_BIST_ADDR,
    input  logic [63:0] A_BIST_DIN,
    input  logic [63:0] A_BIST_BM
);
    logic [63:0] r_mem [2048];
    logic        w_men, w_wen, w_ren;
    logic [10:0] w_addr;
    logic [63:0] w_din, w_bm;
    logic        w_unused;

    assign w_men    = A_BIST_EN ? A_BIST_MEN  : A_MEN;
    assign w_wen    = A_BIST_EN ? A_BIST_WEN  : A_WEN;
    assign w_ren    = A_BIST_EN ? A_BIST_REN  : A_REN;
    assign w_addr   = A_BIST_EN ? A_BIST_ADDR : A_ADDR;
    assign w_din    = A_BIST_EN ? A_BIST_DIN  : A_DIN;
    assign w_bm     = A_BIST_EN ? A_BIST_BM   : A_BM;
    assign w_unused = A_DLY ^ A_BIST_CLK;

    // NOTE: storage arrays take no reset; their contents come from writes or the init sweep.
    always_ff @(posedge A_CLK) begin
        if (w_men && w_wen) r_mem[w_addr] <= (r_mem[w_addr] & ~w_bm) | (w_din & w_bm);
        if (w_men && w_ren) A_DOUT <= r_mem[w_addr];
    end
endmodule

module sram_tiled_wrapper #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 4096,
    parameter int MACRO_W   = 64,
    parameter int MACRO_D   = 2048,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       CEN,
    input  logic                       WEN,
    input  logic [$clog2(DEPTH)-1:0]   A,
    input  logic [WIDTH-1:0]           D,
    input  logic [WIDTH-1:0]           BWEN,
    output logic [WIDTH-1:0]           Q,
    output logic                       Q_VALID,
    output logic                       INIT_DONE
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NCOL   = WIDTH / MACRO_W;
    localparam int NBANK  = DEPTH / MACRO_D;
    localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int MA_W   = $clog2(MACRO_D);

    if (MACRO_W != 64 || MACRO_D != 2048) begin : g_bad_cut
        $error("sram_tiled_wrapper: macro geometry must be 64 x 2048");
    end
    if (WIDTH < MACRO_W || (WIDTH % MACRO_W) != 0) begin : g_bad_width
        $error("sram_tiled_wrapper: WIDTH must be a multiple of MACRO_W");
    end
    if (DEPTH < MACRO_D || (DEPTH % MACRO_D) != 0 || (NBANK & (NBANK - 1)) != 0) begin : g_bad_depth
        $error("sram_tiled_wrapper: DEPTH must be MACRO_D times a power of two");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                      r_state;
    logic [MA_W-1:0]             r_cnt;
    logic [BANK_W-1:0]           r_sel_q;
    logic                        r_q_valid;
    logic                        r_init_done;

    logic                        w_in_init, w_accept, w_rd, w_wr;
    logic [BANK_W-1:0]           w_bank;
    logic [MA_W-1:0]             w_maddr;
    logic [WIDTH-1:0]            w_din, w_bm;
    logic [NBANK-1:0][WIDTH-1:0] w_bank_q;

    assign w_in_init = (r_state == ST_INIT);
    assign w_accept  = (r_state == ST_RUN) && !CEN;
    assign w_rd      = w_accept && WEN;
    assign w_wr      = w_accept && !WEN;
    assign w_maddr   = w_in_init ? r_cnt : A[MA_W-1:0];
    assign w_din     = w_in_init ? '0 : D;
    assign w_bm      = w_in_init ? '1 : ~BWEN;

    if (NBANK > 1) begin : g_bank_decode
        assign w_bank = A[ADDR_W-1 -: BANK_W];
        assign Q      = w_bank_q[r_sel_q];
    end else begin : g_single_bank
        logic w_unused_sel;
        assign w_bank       = '0;
        assign Q            = w_bank_q[0];
        assign w_unused_sel = |r_sel_q;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= INIT_ZERO ? ST_INIT : ST_RUN;
            r_cnt       <= '0;
            r_sel_q     <= '0;
            r_q_valid   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_q_valid <= w_rd;
            if (w_rd) r_sel_q <= w_bank;
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == MA_W'(MACRO_D - 1)) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN:  r_init_done <= 1'b1;
                default: r_state     <= ST_RUN;
            endcase
        end
    end

    assign Q_VALID   = r_q_valid;
    assign INIT_DONE = r_init_done;

    // During the sweep every macro writes zero at r_cnt; afterwards only the addressed bank is enabled.
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic w_hit, w_men, w_wen, w_ren;
        assign w_hit = (w_bank == BANK_W'(b));
        assign w_men = w_in_init | (w_accept & w_hit);
        assign w_wen = w_in_init | (w_wr & w_hit);
        assign w_ren = w_rd & w_hit;

        for (genvar c = 0; c < NCOL; c++) begin : g_col
            RM_IHPSG13_1P_2048x64_c2_bm_bist u_macro (
                .A_CLK       (CLK),
                .A_MEN       (w_men),
                .A_WEN       (w_wen),
                .A_REN       (w_ren),
                .A_ADDR      (w_maddr),
                .A_DIN       (w_din[c*MACRO_W +: MACRO_W]),
                .A_DLY       (1'b1),
                .A_DOUT      (w_bank_q[b][c*MACRO_W +: MACRO_W]),
                .A_BM        (w_bm[c*MACRO_W +: MACRO_W]),
                .A_BIST_CLK  (1'b0),
                .A_BIST_EN   (1'b0),
                .A_BIST_MEN  (1'b0),
                .A_BIST_WEN  (1'b0),
                .A_BIST_REN  (1'b0),
                .A_BIST_ADDR ('0),
                .A_BIST_DIN  ('0),
                .A_BIST_BM   ('0)
            );
        end
    end
endmodule

// File: tb/tb_sram_tiled_wrapper.sv
// Bench for sram_tiled_wrapper: init sweep, table-driven mapping/mask/hold vectors,
// randomized traffic against an array model, reset corner cases and a 64x2048 INIT_ZERO=0 instance.
module tb_sram_tiled_wrapper;
    localparam int WIDTH  = 128;
    localparam int DEPTH  = 4096;
    localparam int ADDR_W = 12;

    logic               CLK = 1'b0;
    logic               RSTN, CEN, WEN;
    logic [ADDR_W-1:0]  A;
    logic [WIDTH-1:0]   D, BWEN, Q;
    logic               Q_VALID, INIT_DONE;

    logic               RSTN2, CEN2, WEN2;
    logic [10:0]        A2;
    logic [63:0]        D2, BWEN2, Q2;
    logic               Q_VALID2, INIT_DONE2;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] mem [DEPTH];

    always #5 CLK = ~CLK;

    sram_tiled_wrapper #(.WIDTH(128), .DEPTH(4096), .INIT_ZERO(1'b1)) dut (
        .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .BWEN(BWEN),
        .Q(Q), .Q_VALID(Q_VALID), .INIT_DONE(INIT_DONE)
    );

    sram_tiled_wrapper #(.WIDTH(64), .DEPTH(2048), .INIT_ZERO(1'b0)) dut2 (
        .CLK(CLK), .RSTN(RSTN2), .CEN(CEN2), .WEN(WEN2), .A(A2), .D(D2), .BWEN(BWEN2),
        .Q(Q2), .Q_VALID(Q_VALID2), .INIT_DONE(INIT_DONE2)
    );

    typedef struct packed {
        logic             cen;
        logic             wen;
        logic [11:0]      a;
        logic [127:0]     d;
        logic [127:0]     bwen;
        logic             exp_valid;
        logic             chk_q;
        logic [127:0]     exp_q;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic cen, input logic wen, input logic [11:0] a,
                                input logic [127:0] d, input logic [127:0] bwen,
                                input logic ev, input logic cq, input logic [127:0] eq);
        vec_t v;
        v.cen = cen; v.wen = wen; v.a = a; v.d = d; v.bwen = bwen;
        v.exp_valid = ev; v.chk_q = cq; v.exp_q = eq;
        return v;
    endfunction

    function automatic vec_t rd(input logic [11:0] a, input logic [127:0] eq);
        return mk(1'b0, 1'b1, a, '0, '1, 1'b1, 1'b1, eq);
    endfunction

    function automatic vec_t wr(input logic [11:0] a, input logic [127:0] d, input logic [127:0] bwen,
                                input logic [127:0] hold_q);
        return mk(1'b0, 1'b0, a, d, bwen, 1'b0, 1'b1, hold_q);
    endfunction

    function automatic vec_t idle(input logic [127:0] hold_q);
        return mk(1'b1, 1'b1, 12'h000, '0, '1, 1'b0, 1'b1, hold_q);
    endfunction

    task automatic drive(input logic cen, input logic wen, input logic [11:0] a,
                         input logic [127:0] d, input logic [127:0] bwen);
        CEN = cen; WEN = wen; A = a; D = d; BWEN = bwen;
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        foreach (mem[i]) mem[i] = '0;
    endtask

    task automatic model_write(input logic [11:0] a, input logic [127:0] d, input logic [127:0] bwen);
        mem[a] = (mem[a] & bwen) | (d & ~bwen);
    endtask

    // Counts clock edges from reset release until INIT_DONE, bounded.
    task automatic wait_init(output int n, output logic saw_valid);
        n = 0;
        saw_valid = 1'b0;
        do begin
            @(posedge CLK);
            #1;
            n++;
            if (Q_VALID) saw_valid = 1'b1;
        end while (!INIT_DONE && n < 3000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] aa, fives, ones, p1, w0, w2, x900, hold_q;
        logic         saw_valid, cen, wen, ev;
        logic [11:0]  ra;
        logic [127:0] rd_, rbw, eq;
        int           n;

        aa    = {16{8'hAA}};
        fives = {16{8'h55}};
        ones  = '1;
        p1    = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        w0    = {4{32'hdead_beef}};
        w2    = {4{32'h1357_9bdf}};
        x900  = {8{16'hc0de}};

        RSTN = 1'b0; CEN = 1'b1; WEN = 1'b1; A = '0; D = '0; BWEN = '1;
        RSTN2 = 1'b0; CEN2 = 1'b1; WEN2 = 1'b1; A2 = '0; D2 = '0; BWEN2 = '1;
        #2;
        check("reset_init_done", {127'd0, INIT_DONE}, 128'd0);
        check("reset_q_valid", {127'd0, Q_VALID}, 128'd0);
        repeat (3) @(posedge CLK);
        #1;

        // Sweep with a write request held on the inputs the whole time; it must be ignored.
        CEN = 1'b0; WEN = 1'b0; A = 12'd5; D = ones; BWEN = '0;
        RSTN = 1'b1;
        wait_init(n, saw_valid);
        check("init_len", 128'(n), 128'd2048);
        check("init_no_q_valid", {127'd0, saw_valid}, 128'd0);
        model_clear();

        tbl.push_back(rd(12'h000, '0));
        tbl.push_back(rd(12'h7FF, '0));
        tbl.push_back(rd(12'h800, '0));
        tbl.push_back(rd(12'hFFF, '0));
        tbl.push_back(rd(12'h005, '0));
        tbl.push_back(idle('0));
        tbl.push_back(wr(12'h003, aa, '0, '0));
        tbl.push_back(wr(12'h803, fives, '0, '0));
        tbl.push_back(rd(12'h003, aa));
        tbl.push_back(rd(12'h803, fives));
        tbl.push_back(wr(12'h900, x900, '0, fives));
        tbl.push_back(rd(12'h900, x900));
        tbl.push_back(wr(12'h007, ones, '0, x900));
        tbl.push_back(wr(12'h007, '0, {{120{1'b1}}, 8'h00}, x900));
        tbl.push_back(rd(12'h007, {{120{1'b1}}, 8'h00}));
        tbl.push_back(wr(12'h001, p1, '0, {{120{1'b1}}, 8'h00}));
        tbl.push_back(rd(12'h001, p1));
        tbl.push_back(wr(12'h801, ones, '0, p1));
        tbl.push_back(wr(12'h802, aa, '0, p1));
        tbl.push_back(wr(12'h8FF, fives, '0, p1));
        tbl.push_back(idle(p1));
        tbl.push_back(idle(p1));
        tbl.push_back(wr(12'h000, w0, '0, p1));
        tbl.push_back(wr(12'h002, w2, '0, p1));
        tbl.push_back(rd(12'h000, w0));
        tbl.push_back(rd(12'h001, p1));
        tbl.push_back(rd(12'h002, w2));
        tbl.push_back(rd(12'h003, aa));

        foreach (tbl[i]) begin
            drive(tbl[i].cen, tbl[i].wen, tbl[i].a, tbl[i].d, tbl[i].bwen);
            check($sformatf("vec%0d_q_valid", i), {127'd0, Q_VALID}, {127'd0, tbl[i].exp_valid});
            if (tbl[i].chk_q) check($sformatf("vec%0d_q", i), Q, tbl[i].exp_q);
            if (!tbl[i].cen && !tbl[i].wen) model_write(tbl[i].a, tbl[i].d, tbl[i].bwen);
        end

        // Random traffic over a small address window in both banks, scored against the array model.
        hold_q = mem[12'h003];
        for (int i = 0; i < 400; i++) begin
            cen = ($urandom_range(0, 3) == 0);
            wen = 1'($urandom_range(0, 1));
            ra  = {1'($urandom_range(0, 1)), 7'd0, 4'($urandom_range(0, 15))};
            rd_ = {$urandom(), $urandom(), $urandom(), $urandom()};
            case ($urandom_range(0, 2))
                0:       rbw = '0;
                1:       rbw = '1;
                default: rbw = {$urandom(), $urandom(), $urandom(), $urandom()};
            endcase
            ev = !cen && wen;
            if (ev) hold_q = mem[ra];
            eq = hold_q;
            drive(cen, wen, ra, rd_, rbw);
            check($sformatf("rnd%0d_q_valid", i), {127'd0, Q_VALID}, {127'd0, ev});
            check($sformatf("rnd%0d_q", i), Q, eq);
            if (!cen && !wen) model_write(ra, rd_, rbw);
        end
        CEN = 1'b1;

        // Single-bank, single-column instance without the sweep.
        check("d2_reset_init_done", {127'd0, INIT_DONE2}, 128'd0);
        RSTN2 = 1'b1;
        #1;
        check("d2_init_done_before_edge", {127'd0, INIT_DONE2}, 128'd0);
        @(posedge CLK);
        #1;
        check("d2_init_done_first_edge", {127'd0, INIT_DONE2}, 128'd1);
        CEN2 = 1'b0; WEN2 = 1'b0; A2 = 11'h123; D2 = 64'h0f1e_2d3c_4b5a_6978; BWEN2 = '0;
        @(posedge CLK); #1;
        check("d2_write_no_valid", {127'd0, Q_VALID2}, 128'd0);
        WEN2 = 1'b1;
        @(posedge CLK); #1;
        check("d2_read_valid", {127'd0, Q_VALID2}, 128'd1);
        check("d2_read_q", {64'd0, Q2}, {64'd0, 64'h0f1e_2d3c_4b5a_6978});
        WEN2 = 1'b0; D2 = '0; BWEN2 = 64'h0000_0000_FFFF_FFFF;
        @(posedge CLK); #1;
        WEN2 = 1'b1;
        @(posedge CLK); #1;
        check("d2_mask_q", {64'd0, Q2}, {64'd0, 64'h0000_0000_4b5a_6978});
        CEN2 = 1'b1;

        // Async reset during a read drops Q_VALID before the next edge.
        drive(1'b0, 1'b1, 12'h001, '0, '1);
        check("pre_reset_q_valid", {127'd0, Q_VALID}, 128'd1);
        CEN = 1'b1;
        #2;
        RSTN = 1'b0;
        #1;
        check("async_reset_q_valid", {127'd0, Q_VALID}, 128'd0);
        check("async_reset_init_done", {127'd0, INIT_DONE}, 128'd0);
        repeat (3) @(posedge CLK);
        #1;
        RSTN = 1'b1;
        repeat (1000) @(posedge CLK);
        #1;
        check("mid_init_not_done", {127'd0, INIT_DONE}, 128'd0);
        RSTN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RSTN = 1'b1;
        wait_init(n, saw_valid);
        check("reinit_len", 128'(n), 128'd2048);
        model_clear();
        drive(1'b0, 1'b1, 12'h003, '0, '1);
        check("reinit_q_valid", {127'd0, Q_VALID}, 128'd1);
        check("reinit_q_zero_b0", Q, mem[12'h003]);
        drive(1'b0, 1'b1, 12'h801, '0, '1);
        check("reinit_q_zero_b1", Q, mem[12'h801]);
        CEN = 1'b1;
        @(posedge CLK);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
